// File: rtl/oki_rom_fetch.sv
// oki_rom_fetch: OKI6295 sample-ROM byte fetch with one-word cache, one-deep pending buffer and fetch timeout.
// Ports:
//   clk_i, reset_n_i        clock, asynchronous active-low reset
//   req_addr_i, req_stb_i   translated byte address and one-cycle request strobe
//   flush_i                 invalidate the cached word
//   data_out_o, data_ok_o   returned byte and its one-cycle valid pulse
//   busy_o                  fetch in flight or request pending
//   rom_addr_o, rom_cs_o    ROM word address and level read request
//   rom_data_i, rom_ok_i    ROM word and its valid
//   err_o, pend_ovf_o       sticky timeout / pending-overwrite flags
module oki_rom_fetch #(
  parameter int AW = 21,
  parameter bit HI_BYTE_FIRST = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic          req_stb_i,
  input  logic          flush_i,
  output logic [7:0]    data_out_o,
  output logic          data_ok_o,
  output logic          busy_o,
  output logic [AW-2:0] rom_addr_o,
  output logic          rom_cs_o,
  input  logic [15:0]   rom_data_i,
  input  logic          rom_ok_i,
  output logic          err_o,
  output logic          pend_ovf_o
);
  typedef enum logic {IDLE, FETCH} state_e;
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d, pend_addr_q, pend_addr_d, src;
  logic [AW-2:0] tag_q, tag_d;
  logic [15:0] cdata_q, cdata_d;
  logic [7:0] dout_q, dout_d, cnt_q, cnt_d;
  logic cval_q, cval_d, pend_v_q, pend_v_d, drop_q, drop_d, cs_q, cs_d;
  logic ok_q, ok_d, err_q, err_d, ovf_q, ovf_d;
  logic req, hit, accept, tmo;

  function automatic logic [7:0] pick(input logic [15:0] w, input logic b0);
    return (b0 ^ HI_BYTE_FIRST) ? w[15:8] : w[7:0];
  endfunction

  always_comb begin
    src = req_stb_i ? req_addr_i : pend_addr_q;
    req = req_stb_i | pend_v_q;
    // a flush in the same cycle forces a miss so the request sees fresh ROM data
    hit = cval_q && tag_q == src[AW-1:1] && !flush_i;
    // cnt_q==0 marks the first FETCH cycle, where a leftover OK must be ignored
    accept = cnt_q != 8'd0 && rom_ok_i;
    tmo = cnt_q == 8'(TIMEOUT - 1);
    state_d = state_q;
    addr_d = addr_q;
    pend_addr_d = pend_addr_q;
    tag_d = tag_q;
    cdata_d = cdata_q;
    dout_d = dout_q;
    cnt_d = cnt_q;
    cval_d = cval_q;
    pend_v_d = pend_v_q;
    drop_d = drop_q;
    cs_d = cs_q;
    ok_d = 1'b0;
    err_d = err_q;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      drop_d = 1'b0;
      if (flush_i) cval_d = 1'b0;
      if (req) begin
        if (!req_stb_i) pend_v_d = 1'b0;
        if (hit) begin
          dout_d = pick(cdata_q, src[0]);
          ok_d = 1'b1;
        end else begin
          addr_d = src;
          cs_d = 1'b1;
          cnt_d = 8'd0;
          state_d = FETCH;
        end
      end
    end else begin
      cnt_d = cnt_q + 8'd1;
      if (flush_i) drop_d = 1'b1;
      if (req_stb_i) begin
        pend_addr_d = req_addr_i;
        pend_v_d = 1'b1;
        if (pend_v_q) ovf_d = 1'b1;
      end
      if (accept) begin
        tag_d = addr_q[AW-1:1];
        cdata_d = rom_data_i;
        cval_d = !(drop_q || flush_i);
        dout_d = pick(rom_data_i, addr_q[0]);
        ok_d = 1'b1;
        cs_d = 1'b0;
        state_d = IDLE;
      end else if (tmo) begin
        dout_d = 8'h00;
        ok_d = 1'b1;
        err_d = 1'b1;
        cs_d = 1'b0;
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q <= '0;
      pend_addr_q <= '0;
      tag_q <= '0;
      cdata_q <= '0;
      dout_q <= '0;
      cnt_q <= '0;
      cval_q <= 1'b0;
      pend_v_q <= 1'b0;
      drop_q <= 1'b0;
      cs_q <= 1'b0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      pend_addr_q <= pend_addr_d;
      tag_q <= tag_d;
      cdata_q <= cdata_d;
      dout_q <= dout_d;
      cnt_q <= cnt_d;
      cval_q <= cval_d;
      pend_v_q <= pend_v_d;
      drop_q <= drop_d;
      cs_q <= cs_d;
      ok_q <= ok_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
    end
  end

  assign data_out_o = dout_q;
  assign data_ok_o = ok_q;
  assign busy_o = state_q == FETCH || pend_v_q;
  assign rom_addr_o = addr_q[AW-1:1];
  assign rom_cs_o = cs_q;
  assign err_o = err_q;
  assign pend_ovf_o = ovf_q;
endmodule

// File: tb/tb_oki_rom_fetch.sv
// tb_oki_rom_fetch: scoreboard bench driving a high-byte-first and a low-byte-first instance with identical stimulus.
module tb_oki_rom_fetch;
  logic clk = 1'b0, rst_n = 1'b0, stb = 1'b0, flush = 1'b0, rom_ok = 1'b0;
  logic [20:0] addr = '0;
  logic [15:0] rom_data = '0;
  logic [7:0] dout_hi, dout_lo, eh, el;
  logic ok_hi, ok_lo, busy_hi, busy_lo, cs_hi, cs_lo, err_hi, err_lo, ovf_hi, ovf_lo;
  logic [19:0] radr_hi, radr_lo;
  logic [7:0] q_hi[$], q_lo[$];
  int checks = 0, errors = 0, pulses = 0, p0, n;

  always #5 clk = ~clk;

  oki_rom_fetch #(.AW(21), .HI_BYTE_FIRST(1'b1), .TIMEOUT(255)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .req_addr_i(addr), .req_stb_i(stb), .flush_i(flush),
    .data_out_o(dout_hi), .data_ok_o(ok_hi), .busy_o(busy_hi), .rom_addr_o(radr_hi),
    .rom_cs_o(cs_hi), .rom_data_i(rom_data), .rom_ok_i(rom_ok), .err_o(err_hi), .pend_ovf_o(ovf_hi));

  oki_rom_fetch #(.AW(21), .HI_BYTE_FIRST(1'b0), .TIMEOUT(255)) dut_lo (
    .clk_i(clk), .reset_n_i(rst_n), .req_addr_i(addr), .req_stb_i(stb), .flush_i(flush),
    .data_out_o(dout_lo), .data_ok_o(ok_lo), .busy_o(busy_lo), .rom_addr_o(radr_lo),
    .rom_cs_o(cs_lo), .rom_data_i(rom_data), .rom_ok_i(rom_ok), .err_o(err_lo), .pend_ovf_o(ovf_lo));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [20:0] a);
    addr = a;
    stb = 1'b1;
    tick();
    stb = 1'b0;
  endtask

  task automatic push(input logic [7:0] h, input logic [7:0] l);
    q_hi.push_back(h);
    q_lo.push_back(l);
  endtask

  task automatic rom_reply(input int w, input logic [15:0] d);
    repeat (w) tick();
    rom_ok = 1'b1;
    rom_data = d;
    tick();
    rom_ok = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ok_hi) begin
      pulses++;
      checks++;
      if (q_hi.size() == 0) begin
        errors++;
        $display("FAIL data_hi: unexpected DATA_OK with %h", dout_hi);
      end else begin
        eh = q_hi.pop_front();
        if (dout_hi !== eh) begin
          errors++;
          $display("FAIL data_hi: got %h expected %h", dout_hi, eh);
        end
      end
    end
    if (ok_lo) begin
      checks++;
      if (q_lo.size() == 0) begin
        errors++;
        $display("FAIL data_lo: unexpected DATA_OK with %h", dout_lo);
      end else begin
        el = q_lo.pop_front();
        if (dout_lo !== el) begin
          errors++;
          $display("FAIL data_lo: got %h expected %h", dout_lo, el);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset outs", {dout_hi, ok_hi, cs_hi, busy_hi, err_hi, ovf_hi}, 32'h0);
    chk("reset rom_addr", 32'(radr_hi), 32'h0);
    chk("reset lo outs", {dout_lo, ok_lo, cs_lo, busy_lo, err_lo, ovf_lo, radr_lo}, 32'h0);
    rst_n = 1'b1;
    tick();
    // first miss, ROM answers 3 cycles after CS rises
    strobe(21'h000400);
    chk("miss cs", 32'(cs_hi), 32'h1);
    chk("miss rom_addr", 32'(radr_hi), 32'h200);
    chk("miss busy", 32'(busy_hi), 32'h1);
    push(8'hA5, 8'h5A);
    rom_reply(3, 16'hA55A);
    chk("ret ok", 32'(ok_hi), 32'h1);
    chk("ret cs low", 32'(cs_hi), 32'h0);
    chk("ret lo addr", 32'(radr_lo), 32'h200);
    tick();
    chk("ret single pulse", 32'(ok_hi), 32'h0);
    // hit on the other byte of the cached word
    push(8'h5A, 8'hA5);
    strobe(21'h000401);
    chk("hit latency1", 32'(ok_hi), 32'h1);
    chk("hit cs", 32'(cs_hi), 32'h0);
    tick();
    // miss with two requests arriving during the fetch
    p0 = pulses;
    strobe(21'h010000);
    push(8'h11, 8'h22);
    push(8'h33, 8'h44);
    tick();
    strobe(21'h010002);
    chk("pend no ovf yet", 32'(ovf_hi), 32'h0);
    strobe(21'h010004);
    chk("pend ovf", 32'(ovf_hi), 32'h1);
    chk("pend busy", 32'(busy_hi), 32'h1);
    rom_reply(0, 16'h1122);
    rom_data = 16'h0;
    chk("pend ret ok", 32'(ok_hi), 32'h1);
    tick();
    chk("pend fetch cs", 32'(cs_hi), 32'h1);
    chk("pend fetch addr", 32'(radr_hi), 32'h8002);
    rom_reply(1, 16'h3344);
    repeat (4) tick();
    chk("pend two pulses", 32'(pulses - p0), 32'h2);
    chk("pend idle", {cs_hi, busy_hi}, 32'h0);
    // timeout: stale OK in the first FETCH cycle must be ignored
    strobe(21'h030000);
    push(8'h00, 8'h00);
    chk("to no err yet", 32'(err_hi), 32'h0);
    rom_ok = 1'b1;
    rom_data = 16'hDEAD;
    tick();
    rom_ok = 1'b0;
    n = 1;
    while (cs_hi && n < 400) begin
      tick();
      n++;
    end
    chk("to cs cycles", 32'(n), 32'd255);
    chk("to ok", 32'(ok_hi), 32'h1);
    chk("to err", 32'(err_hi), 32'h1);
    chk("to dout", 32'(dout_hi), 32'h0);
    tick();
    push(8'h44, 8'h33);
    strobe(21'h010005);
    chk("to cache kept", 32'(ok_hi), 32'h1);
    tick();
    // flush during fetch: data returned but not cached
    strobe(21'h020000);
    push(8'h55, 8'h66);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rom_reply(0, 16'h5566);
    tick();
    strobe(21'h020001);
    chk("flush refetch cs", 32'(cs_hi), 32'h1);
    chk("flush refetch no ok", 32'(ok_hi), 32'h0);
    push(8'h66, 8'h55);
    rom_reply(1, 16'h5566);
    tick();
    // flush coinciding with a request to the cached word
    flush = 1'b1;
    strobe(21'h020000);
    flush = 1'b0;
    chk("flush+stb miss", 32'(cs_hi), 32'h1);
    push(8'h55, 8'h66);
    rom_reply(1, 16'h5566);
    tick();
    // asynchronous reset in the middle of a fetch
    strobe(21'h040000);
    tick();
    chk("rst pre cs", 32'(cs_hi), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst async cs", 32'(cs_hi), 32'h0);
    chk("rst async flags", {busy_hi, err_hi, ovf_hi}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    strobe(21'h020001);
    chk("rst cache invalid", 32'(cs_hi), 32'h1);
    push(8'h66, 8'h55);
    rom_reply(1, 16'h5566);
    repeat (3) tick();
    chk("queue hi drained", 32'(q_hi.size()), 32'h0);
    chk("queue lo drained", 32'(q_lo.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
